pwm_deadband: RTL

- Complementary-output stage directly downstream of the PWM generator.
- Consumes the generator's single-ended PWM output (epwm or ppwm, same clock domain).
- Drives a high-side/low-side driver pair (out_hi, out_lo) with programmable dead time, so the two outputs are never high together.
- Adds a latched fault shutdown and an enable gate for the half-bridge.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_deadband_if.sv | 42 ++++
 rtl/pwm_dtcounter.sv | 36 +++
 rtl/pwm_deadband.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the pwm_deadband complementary output stage: FSM state encoding and defaults.
package pwm_pkg;

  localparam int unsigned DtWidthDefault = 8;

  // Encoding is visible on the debug state port, so the values are fixed.
  typedef enum logic [2:0] {
    StOff  = 3'd0,
    StHi   = 3'd1,
    StLo   = 3'd2,
    StDtHi = 3'd3,
    StDtLo = 3'd4
  } pwm_state_e;

  function automatic logic is_dead_phase(pwm_state_e s);
    return (s == StDtHi) || (s == StDtLo);
  endfunction

  function automatic logic is_drive_phase(pwm_state_e s);
    return (s == StHi) || (s == StLo);
  endfunction

endpackage

// File: rtl/pwm_deadband_if.sv
// Control/status bundle of the pwm_deadband stage.
// PWM_DEADBAND_MINPULSE_EN adds the min_on minimum-pulse input.
interface pwm_deadband_if #(
  parameter int unsigned DT_WIDTH = pwm_pkg::DtWidthDefault
) ();

  logic                pwm_in;
  logic                enable;
  logic [DT_WIDTH-1:0] dead;
  logic                fault;
  logic                fault_clr;
`ifdef PWM_DEADBAND_MINPULSE_EN
  logic [DT_WIDTH-1:0] min_on;
`endif
  logic                out_hi;
  logic                out_lo;
  logic                fault_latched;
  logic [2:0]          state;

`ifdef PWM_DEADBAND_MINPULSE_EN
  modport master (
    output pwm_in, enable, dead, fault, fault_clr, min_on,
    input  out_hi, out_lo, fault_latched, state
  );

  modport slave (
    input  pwm_in, enable, dead, fault, fault_clr, min_on,
    output out_hi, out_lo, fault_latched, state
  );
`else
  modport master (
    output pwm_in, enable, dead, fault, fault_clr,
    input  out_hi, out_lo, fault_latched, state
  );

  modport slave (
    input  pwm_in, enable, dead, fault, fault_clr,
    output out_hi, out_lo, fault_latched, state
  );
`endif

endinterface

// File: rtl/pwm_dtcounter.sv
// Loadable down-counter; saturates at zero and flags expiry while holding the value 1.
module pwm_dtcounter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] value_o,
  output logic             expire_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o  = cnt_q;
  assign expire_o = (cnt_q == Width'(1));

endmodule

// File: rtl/pwm_deadband.sv
// Complementary half-bridge drive with programmable dead time, latched fault and enable gate.
// Define PWM_DEADBAND_MINPULSE_EN to add a minimum on-time for the HI/LO phases.
module pwm_deadband
  import pwm_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DtWidthDefault
) (
  input logic            clk,
  input logic            reset,
  pwm_deadband_if.slave  bus
);

  pwm_state_e state_q, state_d;
  logic       out_hi_q, out_lo_q;
  logic       fault_latched_q, fault_latched_d;

  logic [DT_WIDTH-1:0] dead_load;
  logic [DT_WIDTH-1:0] dt_value;
  logic                dt_load, dt_dec, dt_expire, dt_done;
  logic                min_ok;

  // A zero dead time still needs one both-low clock.
  assign dead_load = (bus.dead == '0) ? DT_WIDTH'(1) : bus.dead;
  assign dt_load   = is_dead_phase(state_d) && !is_dead_phase(state_q);
  assign dt_dec    = is_dead_phase(state_q);
  assign dt_done   = dt_expire || (dt_value == '0);

  pwm_dtcounter #(
    .Width (DT_WIDTH)
  ) u_dead_cnt (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (dt_load),
    .load_val_i (dead_load),
    .dec_i      (dt_dec),
    .value_o    (dt_value),
    .expire_o   (dt_expire)
  );

`ifdef PWM_DEADBAND_MINPULSE_EN
  logic [DT_WIDTH-1:0] min_value;
  logic                min_load, min_dec, min_expire;

  assign min_load = is_drive_phase(state_d) && (state_d != state_q);
  assign min_dec  = is_drive_phase(state_q);
  // The edge where the counter leaves 1 is the first one allowed to switch.
  assign min_ok   = min_expire || (min_value == '0);

  pwm_dtcounter #(
    .Width (DT_WIDTH)
  ) u_min_cnt (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (min_load),
    .load_val_i (bus.min_on),
    .dec_i      (min_dec),
    .value_o    (min_value),
    .expire_o   (min_expire)
  );
`else
  assign min_ok = 1'b1;
`endif

  always_comb begin
    state_d         = state_q;
    fault_latched_d = fault_latched_q & ~bus.fault_clr;
    if (bus.fault) begin
      state_d         = StOff;
      fault_latched_d = 1'b1;
    end else if (!bus.enable) begin
      state_d = StOff;
    end else begin
      unique case (state_q)
        StOff: begin
          if (!fault_latched_q) begin
            state_d = bus.pwm_in ? StDtHi : StDtLo;
          end
        end
        StHi: begin
          if (!bus.pwm_in && min_ok) begin
            state_d = StDtLo;
          end
        end
        StLo: begin
          if (bus.pwm_in && min_ok) begin
            state_d = StDtHi;
          end
        end
        StDtHi, StDtLo: begin
          // Level at expiry decides, so a pulse shorter than the dead time is swallowed.
          if (dt_done) begin
            state_d = bus.pwm_in ? StHi : StLo;
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StOff;
      out_hi_q        <= 1'b0;
      out_lo_q        <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      out_hi_q        <= (state_d == StHi);
      out_lo_q        <= (state_d == StLo);
      fault_latched_q <= fault_latched_d;
    end
  end

  assign bus.out_hi        = out_hi_q;
  assign bus.out_lo        = out_lo_q;
  assign bus.fault_latched = fault_latched_q;
  assign bus.state         = state_q;

  a_never_both : assert property (@(posedge clk) disable iff (!reset) !(out_hi_q && out_lo_q));
  a_fault_off  : assert property (@(posedge clk) disable iff (!reset)
                                  fault_latched_q |-> (state_q == StOff));

endmodule
